reg_writeback_unit: RTL and testbench
=====================================

# reg_writeback_unit

Drives the register file's single write port (`reg_write`, `rd_addr`, `write_data`). It merges two result sources:
- a single-cycle ALU path with no backpressure;
- a variable-latency memory/load path with valid/ready handshake, buffered in a small FIFO.

It also keeps a busy scoreboard of registers with outstanding loads, so the issue stage can detect hazards. It sits between the execute/memory stages and the register file.

## Interface
Parameters:
- `DEPTH`, 4 — memory-result FIFO entries; power of two, ≥2.
- `STARVE_LIMIT`, 3 — consecutive cycles a non-empty FIFO head may lose to the ALU before the ALU is stalled; 1..15.

Ports:
- `clk` in 1 — clock; all state updates on the rising edge.
- `rst` in 1 — reset. **Synchronous and active-high.**
- `alu_valid` in 1 — ALU result present this cycle.
- `alu_rd` in 5 — ALU destination register.
- `alu_data` in 32 — ALU result.
- `alu_stall` out 1 — ALU result not accepted this cycle; upstream holds `alu_*` stable.
- `mem_valid` in 1 — load result offered.
- `mem_ready` out 1 — unit can accept a load result (`!full`).
- `mem_rd` in 5 — load destination register.
- `mem_data` in 32 — load data.
- `issue_valid` in 1 — a load is being issued.
- `issue_rd` in 5 — destination of the issued load.
- `busy_mask` out 32 — bit n set means register n has an outstanding load.
- `reg_write` out 1 — register-file write enable (registered).
- `rd_addr` out 5 — write address (registered).
- `write_data` out 32 — write data (registered).

## Operation
- A memory transfer occurs when `mem_valid && mem_ready`.
- Selection each cycle, in priority order:
  1. If `starve_cnt == STARVE_LIMIT` and the FIFO is non-empty: pop the FIFO head and assert `alu_stall`. The ALU is not accepted.
  2. Else if `alu_valid`: accept the ALU result. If the FIFO is non-empty, `starve_cnt` increments.
  3. Else if the FIFO is non-empty: pop the head.
  4. Else nothing is written.
- `starve_cnt` clears whenever the FIFO pops or becomes empty. It never exceeds `STARVE_LIMIT`.
- The selected result is registered onto `rd_addr`/`write_data` with `reg_write=1`. If the selected destination is 0, `reg_write=0`, but the entry is still consumed.
- The FIFO supports push and pop in the same cycle, including when full. `mem_ready` is registered as `!full`, so a pop in a full cycle does not allow a same-cycle push.
- Scoreboard:
  - `issue_valid` sets `busy_mask[issue_rd]`.
  - A popped memory result clears `busy_mask[rd]`.
  - If the same register is set and cleared in the same cycle, set wins.
  - Bit 0 is always 0.
  - ALU writes never change `busy_mask`.
- `busy_mask` is registered and reflects the previous edge's updates.

## Timing
- Reset values: `reg_write=0`, `rd_addr=0`, `write_data=0`, `busy_mask=0`, `alu_stall=0`. The FIFO is empty, `starve_cnt=0`, and `mem_ready=0` during reset, then 1 in the first cycle after reset.
- Reset asserted mid-operation discards all FIFO contents and scoreboard bits on that edge.
- ALU latency: `alu_valid` in cycle t gives `reg_write` in cycle t+1, so the register file is updated at the end of t+1.
- Memory latency (FIFO path): accept in t, pop in t+1, `reg_write` in t+2.
- `alu_stall` is combinational from `starve_cnt` and FIFO state. It is never asserted when the FIFO is empty.

## Configuration
- `WB_MEM_BYPASS_EN`
  - Defined: when the FIFO is empty, `alu_valid=0`, and a memory transfer occurs, that result is selected directly in the same cycle without entering the FIFO. Memory latency becomes 1 (`reg_write` in t+1), and the scoreboard clear happens on that edge.
  - Undefined: every memory result passes through the FIFO, with latency 2.
  - All other behaviour is identical.

## Test plan
- Reset and ALU writes:
  - Stimulus: hold `rst` for 2 cycles, check all outputs are 0. Then apply `alu_valid=1`, `alu_rd=5`, `alu_data=0xDEADBEEF` for one cycle.
  - Required response: next cycle `reg_write=1`, `rd_addr=5`, `write_data=0xDEADBEEF`.
  - Stimulus: repeat with `alu_rd=0`.
  - Required response: `reg_write=0`.
- Load scoreboard:
  - Stimulus: `issue_valid`, `issue_rd=7`.
  - Required response: `busy_mask=0x80` one cycle later.
  - Stimulus: `mem_valid`, `mem_rd=7`, `mem_data=0x1234`.
  - Required response: with bypass disabled, write at t+2 and `busy_mask=0` after the pop edge. With bypass enabled, write at t+1.
- FIFO full:
  - Stimulus: hold `alu_valid=1` and offer 4 loads.
  - Required response: `mem_ready` drops to 0 after the 4th accept. No load is lost, and the 5th load is accepted only after a pop.
- Starvation:
  - Stimulus: FIFO holds 1 entry, `alu_valid` held continuously, `STARVE_LIMIT=3`.
  - Required response: 3 ALU writes, then `alu_stall=1` for one cycle, the FIFO entry is written, and the held ALU result is written the following cycle.
- Scoreboard and reset collisions:
  - Stimulus: issue to rd 9 in the same cycle that a load to rd 9 pops.
  - Required response: `busy_mask[9]` remains 1.
  - Stimulus: assert `rst` with 3 FIFO entries pending.
  - Required response: no writes follow, and `busy_mask=0`.

Source files
------------

// File: rtl/reg_writeback_unit.sv
// Merges the single-cycle ALU result and FIFO-buffered load results onto the register-file write port, and tracks a busy mask of registers with outstanding loads.
// Latency: ALU result written 1 cycle after acceptance; a load takes 2 cycles through the FIFO, or 1 cycle when the WB_MEM_BYPASS_EN macro is defined and the bypass applies.
// Backpressure: mem_ready is the registered !full; a FIFO head that keeps losing to the ALU eventually stalls the ALU for one cycle via alu_stall.
module reg_writeback_unit #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   output logic        alu_stall,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_data,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   output logic [31:0] busy_mask,
   output logic        reg_write,
   output logic [4:0]  rd_addr,
   output logic [31:0] write_data
);

   localparam int            PW       = $clog2(DEPTH);
   localparam int            CW       = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [3:0]    LIMIT    = 4'(STARVE_LIMIT);

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_ent_t;

   wb_ent_t       fifo_q [DEPTH];
   wb_ent_t       fifo_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [3:0]    starve_q, starve_d;
   logic          ready_q, ready_d;
   logic [31:0]   busy_q, busy_d;
   logic          wr_en_q, wr_en_d;
   logic [4:0]    wr_rd_q, wr_rd_d;
   logic [31:0]   wr_data_q, wr_data_d;

   logic          fifo_empty;
   logic          mem_xfer;
   logic          push;
   logic          pop;
   logic          bypass;
   wb_ent_t       head;

   // ready is held low while rst is asserted, even though the flop itself resets to "not full"
   assign fifo_empty = (count_q == '0);
   assign mem_ready  = ready_q && !rst;
   assign mem_xfer   = mem_valid && mem_ready;
   assign alu_stall  = (starve_q == LIMIT) && !fifo_empty;
   assign head       = fifo_q[rd_ptr_q];
   assign push       = mem_xfer && !bypass;

   assign busy_mask  = busy_q;
   assign reg_write  = wr_en_q;
   assign rd_addr    = wr_rd_q;
   assign write_data = wr_data_q;

   // write-port arbitration: starved FIFO head, then ALU, then FIFO, then (optionally) bypassed load
   always_comb begin
      pop       = 1'b0;
      bypass    = 1'b0;
      wr_en_d   = 1'b0;
      wr_rd_d   = wr_rd_q;
      wr_data_d = wr_data_q;
      starve_d  = starve_q;
      if (alu_stall) begin
         pop = 1'b1;
      end else if (alu_valid) begin
         wr_en_d   = (alu_rd != 5'd0);
         wr_rd_d   = alu_rd;
         wr_data_d = alu_data;
         // only reachable with starve_q < LIMIT when the FIFO is non-empty, so no overflow
         if (!fifo_empty) begin
            starve_d = starve_q + 4'd1;
         end
      end else if (!fifo_empty) begin
         pop = 1'b1;
      end
`ifdef WB_MEM_BYPASS_EN
      else if (mem_xfer) begin
         bypass = 1'b1;
      end
`endif
      if (pop) begin
         wr_en_d   = (head.rd != 5'd0);
         wr_rd_d   = head.rd;
         wr_data_d = head.data;
         starve_d  = 4'd0;
      end
      if (bypass) begin
         wr_en_d   = (mem_rd != 5'd0);
         wr_rd_d   = mem_rd;
         wr_data_d = mem_data;
      end
      if (fifo_empty) begin
         starve_d = 4'd0;
      end
   end

   // load-result FIFO: pointers, occupancy and the registered not-full flag
   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         fifo_d[wr_ptr_q] = '{rd: mem_rd, data: mem_data};
         wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
      ready_d = (count_d != FULL_CNT);
   end

   // busy scoreboard: load completion clears, issue sets afterwards so set wins, r0 never busy
   always_comb begin
      busy_d = busy_q;
      if (pop) begin
         busy_d[head.rd] = 1'b0;
      end
      if (bypass) begin
         busy_d[mem_rd] = 1'b0;
      end
      if (issue_valid) begin
         busy_d[issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // control state and write-port registers, synchronous reset drops all pending loads
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         starve_q  <= 4'd0;
         ready_q   <= 1'b1;
         busy_q    <= 32'd0;
         wr_en_q   <= 1'b0;
         wr_rd_q   <= 5'd0;
         wr_data_q <= 32'd0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         starve_q  <= starve_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         wr_en_q   <= wr_en_d;
         wr_rd_q   <= wr_rd_d;
         wr_data_q <= wr_data_d;
      end
   end

   // FIFO storage needs no reset: occupancy alone decides what is valid
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Scoreboard bench for reg_writeback_unit: directed stimulus pushes expected writes and status values, a negedge monitor compares.
// Writes are matched in order including the cycle they must appear in; status expectations are tied to a cycle number.
// Stimulus honours alu_stall/mem_ready explicitly in the hand-written vectors.
module tb_reg_writeback_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_stall;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [31:0] busy_mask;
   logic        reg_write;
   logic [4:0]  rd_addr;
   logic [31:0] write_data;

   reg_writeback_unit #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .busy_mask(busy_mask),
      .reg_write(reg_write), .rd_addr(rd_addr), .write_data(write_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

`ifdef WB_MEM_BYPASS_EN
   localparam int MEM_LAT = 1;
`else
   localparam int MEM_LAT = 2;
`endif

   localparam int K_RW = 0, K_RD = 1, K_WD = 2, K_BUSY = 3, K_STALL = 4, K_MRDY = 5;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] val;
   } stat_t;

   exp_t  exp_q [$];
   stat_t stat_q[$];
   exp_t  e;
   stat_t s;
   logic [31:0] act;
   int    checks   = 0;
   int    failures = 0;
   logic  done     = 1'b0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expw(input logic [4:0] rd, input logic [31:0] d, input int lat);
      exp_q.push_back('{rd: rd, data: d, cyc: cyc + lat});
   endtask

   task automatic expst(input int kind, input logic [31:0] v);
      stat_q.push_back('{cyc: cyc, kind: kind, val: v});
   endtask

   task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      alu_valid = v; alu_rd = rd; alu_data = d;
   endtask

   task automatic mem(input logic v, input logic [4:0] rd, input logic [31:0] d);
      mem_valid = v; mem_rd = rd; mem_data = d;
   endtask

   // monitor: every presented write pops the scoreboard, status expectations are checked in their cycle
   always @(negedge clk) begin
      if (reg_write === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write cyc=%0d got rd=%0d data=%h, required no write", cyc, rd_addr, write_data);
         end else begin
            e = exp_q.pop_front();
            if (rd_addr !== e.rd || write_data !== e.data || cyc != e.cyc) begin
               failures++;
               $display("FAIL write got rd=%0d data=%h cyc=%0d, required rd=%0d data=%h cyc=%0d",
                        rd_addr, write_data, cyc, e.rd, e.data, e.cyc);
            end
         end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         checks++;
         failures++;
         e = exp_q.pop_front();
         $display("FAIL missing_write cyc=%0d required rd=%0d data=%h", cyc, e.rd, e.data);
      end
      while (stat_q.size() > 0 && stat_q[0].cyc <= cyc) begin
         s = stat_q.pop_front();
         case (s.kind)
            K_RW:    act = {31'd0, reg_write};
            K_RD:    act = {27'd0, rd_addr};
            K_WD:    act = write_data;
            K_BUSY:  act = busy_mask;
            K_STALL: act = {31'd0, alu_stall};
            default: act = {31'd0, mem_ready};
         endcase
         checks++;
         if (act !== s.val) begin
            failures++;
            $display("FAIL status kind=%0d cyc=%0d got %h, required %h", s.kind, cyc, act, s.val);
         end
      end
      if (done) begin
         checks++;
         if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d writes outstanding, required 0", exp_q.size());
         end
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   initial begin
      rst = 1'b1;
      alu(1'b0, 5'd0, 32'd0);
      mem(1'b0, 5'd0, 32'd0);
      issue_valid = 1'b0; issue_rd = 5'd0;

      // reset values
      step(); step();
      expst(K_RW, 0); expst(K_RD, 0); expst(K_WD, 0);
      expst(K_BUSY, 0); expst(K_STALL, 0); expst(K_MRDY, 0);
      step();
      rst = 1'b0;
      #1;
      expst(K_MRDY, 1);

      // ALU writes, then rd 0 suppressed
      alu(1'b1, 5'd5, 32'hDEADBEEF); expw(5'd5, 32'hDEADBEEF, 1);
      step();
      alu(1'b1, 5'd0, 32'h11111111);
      step();
      alu(1'b0, 5'd0, 32'd0);
      expst(K_RW, 0);

      // load scoreboard
      step();
      issue_valid = 1'b1; issue_rd = 5'd7;
      step();
      issue_valid = 1'b0;
      expst(K_BUSY, 32'h80);
      mem(1'b1, 5'd7, 32'h1234); expw(5'd7, 32'h1234, MEM_LAT);
      step();
      mem(1'b0, 5'd0, 32'd0);
      expst(K_BUSY, (MEM_LAT == 1) ? 32'h0 : 32'h80);
      step();
      expst(K_BUSY, 32'h0);
      step();

      // FIFO full with the ALU held busy; starvation kicks in on the 5th cycle
      for (int i = 0; i < 4; i++) begin
         expst(K_MRDY, 1);
         alu(1'b1, 5'd10, 32'hA0000000 + i); expw(5'd10, 32'hA0000000 + i, 1);
         mem(1'b1, 5'(11 + i), 32'hB0000000 + i);
         step();
      end
      expst(K_MRDY, 0); expst(K_STALL, 1);
      alu(1'b1, 5'd10, 32'hA0000004);
      mem(1'b1, 5'd15, 32'hB0000004);
      expw(5'd11, 32'hB0000000, 1);
      step();
      expst(K_MRDY, 1); expst(K_STALL, 0);
      expw(5'd10, 32'hA0000004, 1);
      expw(5'd12, 32'hB0000001, 2);
      expw(5'd13, 32'hB0000002, 3);
      expw(5'd14, 32'hB0000003, 4);
      expw(5'd15, 32'hB0000004, 5);
      step();
      alu(1'b0, 5'd0, 32'd0);
      mem(1'b0, 5'd0, 32'd0);
      repeat (5) step();

      // starvation with one FIFO entry
      expst(K_STALL, 0);
      alu(1'b1, 5'd20, 32'hC0000000); expw(5'd20, 32'hC0000000, 1);
      mem(1'b1, 5'd16, 32'h55550001);
      step();
      mem(1'b0, 5'd0, 32'd0);
      for (int i = 1; i < 4; i++) begin
         expst(K_STALL, 0);
         alu(1'b1, 5'd20, 32'hC0000000 + i); expw(5'd20, 32'hC0000000 + i, 1);
         step();
      end
      expst(K_STALL, 1);
      alu(1'b1, 5'd20, 32'hC0000004);
      expw(5'd16, 32'h55550001, 1);
      step();
      expst(K_STALL, 0);
      expw(5'd20, 32'hC0000004, 1);
      step();
      alu(1'b0, 5'd0, 32'd0);
      step(); step();

      // set and clear of rd 9 in the same cycle: set wins
      issue_valid = 1'b1; issue_rd = 5'd9;
      step();
      issue_valid = 1'b0;
      expst(K_BUSY, 32'h200);
      alu(1'b1, 5'd21, 32'hD0000000); expw(5'd21, 32'hD0000000, 1);
      mem(1'b1, 5'd9, 32'h00009999);
      step();
      alu(1'b0, 5'd0, 32'd0);
      mem(1'b0, 5'd0, 32'd0);
      issue_valid = 1'b1; issue_rd = 5'd9;
      expw(5'd9, 32'h00009999, 1);
      step();
      issue_valid = 1'b0;
      expst(K_BUSY, 32'h200);
      step();

      // reset with three loads pending
      issue_valid = 1'b1; issue_rd = 5'd23;
      alu(1'b1, 5'd22, 32'hE0000000); expw(5'd22, 32'hE0000000, 1);
      mem(1'b1, 5'd23, 32'hF0000001);
      step();
      issue_valid = 1'b0;
      alu(1'b1, 5'd22, 32'hE0000001); expw(5'd22, 32'hE0000001, 1);
      mem(1'b1, 5'd24, 32'hF0000002);
      step();
      alu(1'b1, 5'd22, 32'hE0000002); expw(5'd22, 32'hE0000002, 1);
      mem(1'b1, 5'd25, 32'hF0000003);
      step();
      alu(1'b0, 5'd0, 32'd0);
      mem(1'b0, 5'd0, 32'd0);
      expst(K_BUSY, 32'h00800200);
      rst = 1'b1;
      step();
      rst = 1'b0;
      expst(K_BUSY, 32'h0); expst(K_RW, 0); expst(K_STALL, 0);
      repeat (6) step();
      expst(K_BUSY, 32'h0);
      step();

      done = 1'b1;
      #1000;
      $display("FAIL monitor_finish did not reach summary");
      $fatal(1);
   end

endmodule
